// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, immediate formats, ALU operations,
// writeback sources and the bundled EX-stage control word.
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_IMM  = 2'd3
  } result_src_t;

  // Control fields carried from decode into the EX stage.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    result_src_t result_src;
    alu_op_t     alu_op;
    logic [2:0]  funct3;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/main_decoder.sv
// Purely combinational RV32I main decoder: instruction word to EX control
// word, immediate format, register fields and register-use flags.
// Unsupported encodings come back with ctrl.illegal set, all other control
// cleared and no registers marked as used.
module main_decoder
  import riscv_pkg::*;
(
  input  logic [RV_XLEN-1:0]   instruction,
  output ctrl_t                ctrl,
  output imm_src_t             imm_src,
  output logic                 rs1_used,
  output logic                 rs2_used,
  output logic [RV_REG_AW-1:0] rs1,
  output logic [RV_REG_AW-1:0] rs2,
  output logic [RV_REG_AW-1:0] rd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_reg;
  logic       arith_ok;
  alu_op_t    arith_op;
  logic       legal;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign is_reg = (opcode == OP_REG);

  // ALU operation and legality for OP / OP-IMM from funct3/funct7.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (funct3)
      3'b000: begin
        arith_op = (is_reg && funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
        arith_ok = !is_reg || funct7 == 7'h00 || funct7 == 7'h20;
      end
      3'b001: begin arith_op = ALU_SLL; arith_ok = (funct7 == 7'h00); end
      3'b010: begin arith_op = ALU_SLT; arith_ok = !is_reg || funct7 == 7'h00; end
      3'b100: begin arith_op = ALU_XOR; arith_ok = !is_reg || funct7 == 7'h00; end
      3'b101: begin arith_op = ALU_SRL; arith_ok = (funct7 == 7'h00); end
      3'b110: begin arith_op = ALU_OR;  arith_ok = !is_reg || funct7 == 7'h00; end
      3'b111: begin arith_op = ALU_AND; arith_ok = !is_reg || funct7 == 7'h00; end
      default: arith_ok = 1'b0;  // sltu/sltiu have no ALU operation here
    endcase
  end

  // Opcode decode into control word, immediate format and register use.
  always_comb begin
    ctrl        = CTRL_NOP;
    ctrl.funct3 = funct3;
    imm_src     = IMM_I;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    legal       = 1'b1;
    case (opcode)
      OP_LOAD: begin
        legal           = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_LOAD;
        rs1_used        = 1'b1;
      end
      OP_STORE: begin
        legal          = funct3 inside {3'b000, 3'b001, 3'b010};
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_BRANCH: begin
        legal       = !(funct3 inside {3'b010, 3'b011});
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        imm_src     = IMM_B;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_IMM: begin
        legal          = arith_ok;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = arith_op;
        rs1_used       = 1'b1;
      end
      OP_REG: begin
        legal          = arith_ok;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = arith_op;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_JALR: begin
        legal           = (funct3 == 3'b000);
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        rs1_used        = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_IMM;
        imm_src         = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_U;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
    end
  end

endmodule

// File: rtl/decode_controller.sv
// Decode-stage controller for the 5-stage RV32I pipeline: drives the
// immediate format, detects load-use hazards, generates F/D stall and D
// flush, and owns the ID/EX control register.
// Optional feature macro: ILLEGAL_INSTR_EN -- when defined, unsupported
// encodings enter EX as valid instructions flagged by illegal_e; otherwise
// they enter as bubbles and illegal_e stays 0.
module decode_controller
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   instruction_d,
  input  logic              valid_d,
  input  logic              pc_src_e,
  input  logic              stall_m,
  output logic [2:0]        immediate_source_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic              alu_src_e,
  output logic [1:0]        result_src_e,
  output logic [3:0]        alu_control_e,
  output logic [2:0]        funct3_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              illegal_e
);

  ctrl_t             ctrl_d;
  imm_src_t          imm_src_d;
  logic              rs1_used_raw;
  logic              rs2_used_raw;
  logic              rs1_used_d;
  logic              rs2_used_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              lw_stall;

  ctrl_t             ctrl_next;
  logic              valid_next;
  logic [REG_AW-1:0] rs1_next;
  logic [REG_AW-1:0] rs2_next;
  logic [REG_AW-1:0] rd_next;

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;

  main_decoder u_main_decoder (
    .instruction (instruction_d),
    .ctrl        (ctrl_d),
    .imm_src     (imm_src_d),
    .rs1_used    (rs1_used_raw),
    .rs2_used    (rs2_used_raw),
    .rs1         (rs1_d),
    .rs2         (rs2_d),
    .rd          (rd_d)
  );

  assign immediate_source_d = imm_src_d;

  // An empty decode slot reads no registers, so it can never cause a stall.
  assign rs1_used_d = valid_d & rs1_used_raw;
  assign rs2_used_d = valid_d & rs2_used_raw;

  // Load in EX whose destination is read by the instruction in decode.
  assign lw_stall = valid_q && (ctrl_q.result_src == RES_LOAD) && (rd_q != '0) &&
                    ((rs1_used_d && rd_q == rs1_d) || (rs2_used_d && rd_q == rs2_d));

  assign stall_f = lw_stall | stall_m;
  assign stall_d = lw_stall | stall_m;
  assign flush_d = pc_src_e;

  // Next ID/EX contents: a bubble on flush, load-use stall, empty slot or
  // dropped illegal instruction, otherwise the decoded instruction.
  always_comb begin
    ctrl_next  = CTRL_NOP;
    valid_next = 1'b0;
    rs1_next   = '0;
    rs2_next   = '0;
    rd_next    = '0;
    if (!pc_src_e && !lw_stall && valid_d) begin
      if (!ctrl_d.illegal) begin
        ctrl_next           = ctrl_d;
        ctrl_next.reg_write = ctrl_d.reg_write & (rd_d != '0);
        valid_next          = 1'b1;
        rs1_next            = rs1_used_d ? rs1_d : '0;
        rs2_next            = rs2_used_d ? rs2_d : '0;
        rd_next             = ctrl_next.reg_write ? rd_d : '0;
      end
`ifdef ILLEGAL_INSTR_EN
      else begin
        ctrl_next.illegal = 1'b1;
        valid_next        = 1'b1;
      end
`endif
    end
  end

  // ID/EX register: reset clears, a memory stall freezes, otherwise load next.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (!stall_m) begin
      ctrl_q  <= ctrl_next;
      valid_q <= valid_next;
      rs1_q   <= rs1_next;
      rs2_q   <= rs2_next;
      rd_q    <= rd_next;
    end
  end

  assign valid_e       = valid_q;
  assign reg_write_e   = ctrl_q.reg_write;
  assign mem_write_e   = ctrl_q.mem_write;
  assign branch_e      = ctrl_q.branch;
  assign jump_e        = ctrl_q.jump;
  assign alu_src_e     = ctrl_q.alu_src;
  assign result_src_e  = ctrl_q.result_src;
  assign alu_control_e = ctrl_q.alu_op;
  assign funct3_e      = ctrl_q.funct3;
  assign illegal_e     = ctrl_q.illegal;
  assign rs1_e         = rs1_q;
  assign rs2_e         = rs2_q;
  assign rd_e          = rd_q;

endmodule

// File: tb/tb_decode_controller.sv
// Self-checking bench for decode_controller: directed pipeline scenarios
// followed by randomized traffic, all compared against an instruction-level
// reference model of the ID/EX stage. Honors ILLEGAL_INSTR_EN like the RTL.
module tb_decode_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_d;
  logic        valid_d;
  logic        pc_src_e;
  logic        stall_m;
  logic [2:0]  immediate_source_d;
  logic        stall_f, stall_d, flush_d;
  logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;
  logic [2:0]  funct3_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        illegal_e;

  decode_controller dut (
    .clk                (clk),
    .reset              (reset),
    .instruction_d      (instruction_d),
    .valid_d            (valid_d),
    .pc_src_e           (pc_src_e),
    .stall_m            (stall_m),
    .immediate_source_d (immediate_source_d),
    .stall_f            (stall_f),
    .stall_d            (stall_d),
    .flush_d            (flush_d),
    .valid_e            (valid_e),
    .reg_write_e        (reg_write_e),
    .mem_write_e        (mem_write_e),
    .branch_e           (branch_e),
    .jump_e             (jump_e),
    .alu_src_e          (alu_src_e),
    .result_src_e       (result_src_e),
    .alu_control_e      (alu_control_e),
    .funct3_e           (funct3_e),
    .rs1_e              (rs1_e),
    .rs2_e              (rs2_e),
    .rd_e               (rd_e),
    .illegal_e          (illegal_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected instruction properties from the ISA tables.
  typedef struct packed {
    logic       legal, rw, mw, br, jp, as, u1, u2;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic [2:0] imm;
  } dec_t;

  // Expected contents of the EX slot.
  typedef struct packed {
    logic       valid, ill, rw, mw, br, jp, as;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
  } ex_t;

  // ALU codes for OP/OP-IMM funct3: add sll slt (sltu) xor srl or and.
  int alu_map [8] = '{0, 6, 5, 0, 4, 7, 3, 2};

  int   vectors = 0;
  int   miscompares = 0;
  ex_t  m;
  dec_t cur_dec;
  logic cur_lw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d.legal = 1'b1;
    case (ins[6:0])
      7'h03: begin  // loads: lb lh lw lbu lhu
        d.rw = 1; d.as = 1; d.rsrc = 2'd1; d.u1 = 1;
        d.legal = (f3 != 3'd3) && (f3 < 3'd6);
      end
      7'h23: begin  // stores: sb sh sw
        d.mw = 1; d.as = 1; d.imm = 3'd1; d.u1 = 1; d.u2 = 1;
        d.legal = (f3 < 3'd3);
      end
      7'h63: begin  // beq bne blt bge bltu bgeu
        d.br = 1; d.alu = 4'd1; d.imm = 3'd2; d.u1 = 1; d.u2 = 1;
        d.legal = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h13: begin  // OP-IMM
        d.rw = 1; d.as = 1; d.u1 = 1; d.alu = 4'(alu_map[f3]);
        d.legal = (f3 != 3'd3) && (!(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00);
      end
      7'h33: begin  // OP
        d.rw = 1; d.u1 = 1; d.u2 = 1;
        d.alu = (f7 == 7'h20) ? 4'd1 : 4'(alu_map[f3]);
        d.legal = (f3 != 3'd3) && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
      end
      7'h67: begin  // jalr
        d.rw = 1; d.jp = 1; d.as = 1; d.rsrc = 2'd2; d.u1 = 1;
        d.legal = (f3 == 3'd0);
      end
      7'h6f: begin d.rw = 1; d.jp = 1; d.rsrc = 2'd2; d.imm = 3'd4; end  // jal
      7'h37: begin d.rw = 1; d.as = 1; d.rsrc = 2'd3; d.imm = 3'd3; end  // lui
      7'h17: begin d.rw = 1; d.as = 1; d.imm = 3'd3; end                 // auipc
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) begin
      d.u1 = 0; d.u2 = 0;
    end
    return d;
  endfunction

  // Apply inputs, then on the falling edge compare everything against the model.
  task automatic drive(input logic [31:0] ins, input logic vd, input logic pc,
                       input logic sm, input logic rs);
    reset = rs; instruction_d = ins; valid_d = vd; pc_src_e = pc; stall_m = sm;
    @(negedge clk);
    cur_dec = ref_decode(ins);
    cur_lw  = m.valid && m.rsrc == 2'd1 && m.rd != 5'd0 && vd &&
              ((cur_dec.u1 && ins[19:15] == m.rd) || (cur_dec.u2 && ins[24:20] == m.rd));
    check("imm_src",    32'(immediate_source_d), 32'(cur_dec.imm));
    check("stall_f",    32'(stall_f),       32'(cur_lw || sm));
    check("stall_d",    32'(stall_d),       32'(cur_lw || sm));
    check("flush_d",    32'(flush_d),       32'(pc));
    check("valid_e",    32'(valid_e),       32'(m.valid));
    check("illegal_e",  32'(illegal_e),     32'(m.ill));
    check("reg_write",  32'(reg_write_e),   32'(m.rw));
    check("mem_write",  32'(mem_write_e),   32'(m.mw));
    check("branch_e",   32'(branch_e),      32'(m.br));
    check("jump_e",     32'(jump_e),        32'(m.jp));
    check("alu_src_e",  32'(alu_src_e),     32'(m.as));
    check("result_src", 32'(result_src_e),  32'(m.rsrc));
    check("alu_ctrl",   32'(alu_control_e), 32'(m.alu));
    check("funct3_e",   32'(funct3_e),      32'(m.f3));
    check("rs1_e",      32'(rs1_e),         32'(m.r1));
    check("rs2_e",      32'(rs2_e),         32'(m.r2));
    check("rd_e",       32'(rd_e),          32'(m.rd));
  endtask

  // Advance the model by one clock using the inputs applied by drive().
  task automatic tick();
    ex_t n;
    n = m;
    if (reset) n = '0;
    else if (stall_m) n = m;
    else if (pc_src_e || cur_lw || !valid_d) n = '0;
    else if (!cur_dec.legal) begin
      n = '0;
`ifdef ILLEGAL_INSTR_EN
      n.valid = 1'b1;
      n.ill   = 1'b1;
`endif
    end else begin
      n.valid = 1'b1;
      n.ill   = 1'b0;
      n.rw    = cur_dec.rw && instruction_d[11:7] != 5'd0;
      n.mw    = cur_dec.mw;
      n.br    = cur_dec.br;
      n.jp    = cur_dec.jp;
      n.as    = cur_dec.as;
      n.rsrc  = cur_dec.rsrc;
      n.alu   = cur_dec.alu;
      n.f3    = instruction_d[14:12];
      n.r1    = cur_dec.u1 ? instruction_d[19:15] : 5'd0;
      n.r2    = cur_dec.u2 ? instruction_d[24:20] : 5'd0;
      n.rd    = n.rw ? instruction_d[11:7] : 5'd0;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic step(input logic [31:0] ins, input logic vd, input logic pc,
                      input logic sm, input logic rs);
    drive(ins, vd, pc, sm, rs);
    tick();
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h67, 7'h6f, 7'h37, 7'h17};

  initial begin
    logic [31:0] lw5, add6, lw0, add_x0, lui5, beq, sw7, ill;
    lw5    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);   // lw   x5,0(x1)
    add6   = enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33);   // add  x6,x5,x2
    lw0    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03);   // lw   x0,0(x1)
    add_x0 = enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33);   // add  x6,x0,x2
    lui5   = enc(7'h05, 5'd5, 5'd5, 3'd0, 5'd5, 7'h37);   // lui  x5,... (field bits hit x5)
    beq    = enc(7'h00, 5'd4, 5'd3, 3'd0, 5'd8, 7'h63);   // beq  x3,x4,...
    sw7    = enc(7'h00, 5'd7, 5'd3, 3'd2, 5'd4, 7'h23);   // sw   x7,4(x3)
    ill    = 32'hFFFF_FFFF;

    reset = 1'b1; instruction_d = '0; valid_d = 1'b0; pc_src_e = 1'b0; stall_m = 1'b0;
    @(posedge clk);
    #1;
    m = '0;

    // Reset state, including reset asserted during a memory stall.
    step(lw5, 1, 0, 1, 1);
    drive(32'h0, 0, 0, 0, 0);
    check("rst_valid", 32'(valid_e), 32'd0);
    check("rst_stall", 32'(stall_f), 32'd0);
    tick();

    // Load then dependent add: one bubble, then the add enters EX.
    drive(lw5, 1, 0, 0, 0);
    check("lw_imm", 32'(immediate_source_d), 32'd0);
    tick();
    drive(add6, 1, 0, 0, 0);
    check("lw_rsrc", 32'(result_src_e), 32'd1);
    check("lw_rw",   32'(reg_write_e),  32'd1);
    check("lw_rd",   32'(rd_e),         32'd5);
    check("lu_stall", 32'(stall_d),     32'd1);
    tick();
    drive(add6, 1, 0, 0, 0);
    check("lu_bubble", 32'(valid_e), 32'd0);
    tick();
    drive(32'h0, 0, 0, 0, 0);
    check("add_in_e", 32'(rd_e), 32'd6);
    tick();

    // Loads to x0 never stall; lui after a load reads no registers.
    step(lw0, 1, 0, 0, 0);
    drive(add_x0, 1, 0, 0, 0);
    check("x0_nostall", 32'(stall_f), 32'd0);
    tick();
    step(lw5, 1, 0, 0, 0);
    drive(lui5, 1, 0, 0, 0);
    check("lui_nostall", 32'(stall_f), 32'd0);
    tick();

    // Taken branch flushes decode and bubbles EX.
    drive(beq, 1, 1, 0, 0);
    check("br_flush", 32'(flush_d), 32'd1);
    tick();
    drive(32'h0, 0, 0, 0, 0);
    check("br_bubble", 32'(branch_e), 32'd0);
    tick();

    // Memory stall freezes the store in EX even across a pc_src_e pulse.
    step(sw7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(add6, 1, (i == 1), 1, 0);
      check("sm_hold_mw", 32'(mem_write_e), 32'd1);
      check("sm_stall",   32'(stall_f),     32'd1);
      tick();
    end
    step(32'h0, 0, 0, 0, 0);

    // All-ones word: unknown opcode.
    step(ill, 1, 0, 0, 0);
    drive(32'h0, 0, 0, 0, 0);
`ifdef ILLEGAL_INSTR_EN
    check("ill_flag",  32'(illegal_e),   32'd1);
    check("ill_valid", 32'(valid_e),     32'd1);
    check("ill_rw",    32'(reg_write_e), 32'd0);
    check("ill_mw",    32'(mem_write_e), 32'd0);
`else
    check("ill_flag",  32'(illegal_e),   32'd0);
    check("ill_valid", 32'(valid_e),     32'd0);
`endif
    tick();

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] ins;
      logic [6:0]  f7;
      int          k;
      k  = $urandom_range(0, 9);
      f7 = ($urandom_range(0, 3) == 0) ? 7'h20 :
           ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00;
      if (k == 9) ins = $urandom;
      else ins = enc(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ops[k]);
      step(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
